// File: rtl/axonerve_kvs_rtl_example_job_arbiter_if.sv
// rtl/axonerve_kvs_rtl_example_job_arbiter_if.sv - two-requester command/response bundle for the job arbiter
interface axonerve_kvs_rtl_example_job_arbiter_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_CYCLE_CNT_WIDTH  = 32
);
  logic                          s0_cmd_valid;
  logic                          s0_cmd_ready;
  logic [C_M_AXI_ADDR_WIDTH-1:0] s0_cmd_addr;
  logic [C_XFER_SIZE_WIDTH-1:0]  s0_cmd_size;
  logic [C_ADDER_BIT_WIDTH-1:0]  s0_cmd_constant;
  logic                          s0_rsp_valid;
  logic                          s0_rsp_ready;
  logic [C_CYCLE_CNT_WIDTH-1:0]  s0_rsp_cycles;

  logic                          s1_cmd_valid;
  logic                          s1_cmd_ready;
  logic [C_M_AXI_ADDR_WIDTH-1:0] s1_cmd_addr;
  logic [C_XFER_SIZE_WIDTH-1:0]  s1_cmd_size;
  logic [C_ADDER_BIT_WIDTH-1:0]  s1_cmd_constant;
  logic                          s1_rsp_valid;
  logic                          s1_rsp_ready;
  logic [C_CYCLE_CNT_WIDTH-1:0]  s1_rsp_cycles;

  modport master (
    output s0_cmd_valid, s0_cmd_addr, s0_cmd_size, s0_cmd_constant, s0_rsp_ready,
    input  s0_cmd_ready, s0_rsp_valid, s0_rsp_cycles,
    output s1_cmd_valid, s1_cmd_addr, s1_cmd_size, s1_cmd_constant, s1_rsp_ready,
    input  s1_cmd_ready, s1_rsp_valid, s1_rsp_cycles
  );

  modport slave (
    input  s0_cmd_valid, s0_cmd_addr, s0_cmd_size, s0_cmd_constant, s0_rsp_ready,
    output s0_cmd_ready, s0_rsp_valid, s0_rsp_cycles,
    input  s1_cmd_valid, s1_cmd_addr, s1_cmd_size, s1_cmd_constant, s1_rsp_ready,
    output s1_cmd_ready, s1_rsp_valid, s1_rsp_cycles
  );
endinterface

// File: rtl/axonerve_kvs_rtl_example_job_arbiter.sv
// rtl/axonerve_kvs_rtl_example_job_arbiter.sv - round-robin arbiter sharing one vadd datapath between two requesters
module axonerve_kvs_rtl_example_job_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_CYCLE_CNT_WIDTH  = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  axonerve_kvs_rtl_example_job_arbiter_if.slave req,
  output logic                          ap_start,
  input  logic                          ap_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
  output logic [C_ADDER_BIT_WIDTH-1:0]  ctrl_constant,
  output logic                          busy,
  output logic [31:0]                   job_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [C_CYCLE_CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t                         state;
  state_t                         state_nxt;
  logic                           grant;
  logic                           last_grant;
  logic                           grant_next;
  logic                           accept;
  logic                           rsp_hs;
  logic [C_CYCLE_CNT_WIDTH-1:0]   cycle_cnt;
  logic [C_CYCLE_CNT_WIDTH-1:0]   cycle_cnt_inc;
  logic [C_CYCLE_CNT_WIDTH-1:0]   rsp_cycles;
  logic [C_M_AXI_ADDR_WIDTH-1:0]  sel_addr;
  logic [C_XFER_SIZE_WIDTH-1:0]   sel_size;
  logic [C_ADDER_BIT_WIDTH-1:0]   sel_constant;
  logic                           sel_valid;

  // Round-robin only matters under contention; a lone requester always wins.
  always_comb begin
    if (req.s0_cmd_valid && req.s1_cmd_valid) begin
      grant_next = ~last_grant;
    end else begin
      grant_next = req.s1_cmd_valid;
    end
  end

  always_comb begin
    sel_valid    = grant_next ? req.s1_cmd_valid    : req.s0_cmd_valid;
    sel_addr     = grant_next ? req.s1_cmd_addr     : req.s0_cmd_addr;
    sel_size     = grant_next ? req.s1_cmd_size     : req.s0_cmd_size;
    sel_constant = grant_next ? req.s1_cmd_constant : req.s0_cmd_constant;
  end

  assign accept        = aresetn && (state == IDLE) && sel_valid;
  assign rsp_hs        = aresetn && (state == RESP) &&
                         (grant ? req.s1_rsp_ready : req.s0_rsp_ready);
  assign cycle_cnt_inc = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_ONE;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are held inactive while reset is asserted so an abandoned job
  // never produces a stray start pulse or response.
  always_comb begin
    state_nxt        = state;
    req.s0_cmd_ready = 1'b0;
    req.s1_cmd_ready = 1'b0;
    req.s0_rsp_valid = 1'b0;
    req.s1_rsp_valid = 1'b0;
    ap_start         = 1'b0;
    if (aresetn) begin
      case (state)
        IDLE: begin
          req.s0_cmd_ready = ~grant_next;
          req.s1_cmd_ready = grant_next;
          if (accept) begin
            state_nxt = (sel_size == '0) ? RESP : START;
          end
        end
        START: begin
          ap_start  = 1'b1;
          state_nxt = WAIT;
        end
        WAIT: begin
          if (ap_done) begin
            state_nxt = RESP;
          end
        end
        RESP: begin
          req.s0_rsp_valid = ~grant;
          req.s1_rsp_valid = grant;
          if (rsp_hs) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      grant                   <= 1'b0;
      last_grant              <= 1'b1;
      job_count               <= 32'd0;
      cycle_cnt               <= '0;
      rsp_cycles              <= '0;
      ctrl_addr_offset        <= '0;
      ctrl_xfer_size_in_bytes <= '0;
      ctrl_constant           <= '0;
    end else begin
      if (accept) begin
        grant                   <= grant_next;
        ctrl_addr_offset        <= sel_addr;
        ctrl_xfer_size_in_bytes <= sel_size;
        ctrl_constant           <= sel_constant;
        if (sel_size == '0) begin
          rsp_cycles <= '0;
        end
      end

      // Counter is 0 in the first WAIT cycle, so done-cycle count + 1
      // equals the distance from the start pulse to the done pulse.
      if (state == START) begin
        cycle_cnt <= '0;
      end else if (state == WAIT) begin
        cycle_cnt <= cycle_cnt_inc;
        if (ap_done) begin
          rsp_cycles <= cycle_cnt_inc;
        end
      end

      if (rsp_hs) begin
        last_grant <= grant;
        job_count  <= job_count + 32'd1;
      end
    end
  end

  assign req.s0_rsp_cycles = rsp_cycles;
  assign req.s1_rsp_cycles = rsp_cycles;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_axonerve_kvs_rtl_example_job_arbiter.sv
// tb/tb_axonerve_kvs_rtl_example_job_arbiter.sv - randomized self-checking bench for the job arbiter
module tb_axonerve_kvs_rtl_example_job_arbiter;
  localparam int AW = 64;
  localparam int SW = 32;
  localparam int KW = 32;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          ap_start;
  logic          ap_done = 1'b0;
  logic [AW-1:0] ctrl_addr_offset;
  logic [SW-1:0] ctrl_xfer_size_in_bytes;
  logic [KW-1:0] ctrl_constant;
  logic          busy;
  logic [31:0]   job_count;

  int checks = 0;
  int failures = 0;

  // Reference model: pending command per requester, last served requester, job tally.
  bit            pend [2];
  logic [AW-1:0] pa [2];
  logic [SW-1:0] ps [2];
  logic [KW-1:0] pc [2];
  int            last_served = 1;
  int            exp_jobs = 0;

  always #5 clk = ~clk;

  axonerve_kvs_rtl_example_job_arbiter_if #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_XFER_SIZE_WIDTH(SW),
    .C_ADDER_BIT_WIDTH(KW), .C_CYCLE_CNT_WIDTH(CW)
  ) bus ();

  axonerve_kvs_rtl_example_job_arbiter #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_XFER_SIZE_WIDTH(SW),
    .C_ADDER_BIT_WIDTH(KW), .C_CYCLE_CNT_WIDTH(CW)
  ) dut (
    .aclk                    (clk),
    .aresetn                 (aresetn),
    .req                     (bus),
    .ap_start                (ap_start),
    .ap_done                 (ap_done),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .ctrl_constant           (ctrl_constant),
    .busy                    (busy),
    .job_count               (job_count)
  );

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int n);
    return (n != 0) ? bus.s1_cmd_ready : bus.s0_cmd_ready;
  endfunction

  function automatic logic rspv(input int n);
    return (n != 0) ? bus.s1_rsp_valid : bus.s0_rsp_valid;
  endfunction

  function automatic logic [CW-1:0] rspc(input int n);
    return (n != 0) ? bus.s1_rsp_cycles : bus.s0_rsp_cycles;
  endfunction

  task automatic set_valid(input int n, input bit v);
    if (n != 0) bus.s1_cmd_valid = v;
    else        bus.s0_cmd_valid = v;
  endtask

  task automatic set_rsp_ready(input int n, input bit v);
    if (n != 0) bus.s1_rsp_ready = v;
    else        bus.s0_rsp_ready = v;
  endtask

  task automatic post(input int n, input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [KW-1:0] c);
    pa[n] = a; ps[n] = s; pc[n] = c; pend[n] = 1'b1;
    if (n != 0) begin
      bus.s1_cmd_addr = a; bus.s1_cmd_size = s; bus.s1_cmd_constant = c;
    end else begin
      bus.s0_cmd_addr = a; bus.s0_cmd_size = s; bus.s0_cmd_constant = c;
    end
    set_valid(n, 1'b1);
  endtask

  // Serve one job from IDLE through the response handshake; returns in IDLE.
  task automatic run_job(input int delay, input int bp, input bit spur);
    int            g;
    int            stray;
    int            exp_cyc;
    logic [AW-1:0] ea;
    logic [SW-1:0] es;
    logic [KW-1:0] ec;
    if (pend[0] && pend[1]) g = (last_served == 0) ? 1 : 0;
    else                    g = pend[1] ? 1 : 0;
    ea = pa[g]; es = ps[g]; ec = pc[g];
    #1;
    expect_eq("cmd_ready_grant", rdy(g), 1'b1);
    expect_eq("cmd_ready_other", rdy(1 - g), 1'b0);
    expect_eq("idle_not_busy", busy, 1'b0);
    if (spur) ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    set_valid(g, 1'b0);
    pend[g] = 1'b0;
    expect_eq("ctrl_addr", ctrl_addr_offset, ea);
    expect_eq("ctrl_size", ctrl_xfer_size_in_bytes, es);
    expect_eq("ctrl_const", ctrl_constant, ec);
    expect_eq("busy_after_accept", busy, 1'b1);
    if (es == '0) begin
      expect_eq("zero_no_start", ap_start, 1'b0);
      exp_cyc = 0;
    end else begin
      expect_eq("start_at_t1", ap_start, 1'b1);
      expect_eq("start_cmd_ready", {rdy(0), rdy(1)}, 2'b00);
      if (spur) ap_done = 1'b1;
      step();
      ap_done = 1'b0;
      stray = 0;
      for (int i = 1; i < delay; i++) begin
        if (ap_start || rspv(0) || rspv(1)) stray++;
        step();
      end
      expect_eq("wait_quiet", stray, 0);
      ap_done = 1'b1;
      step();
      ap_done = 1'b0;
      exp_cyc = (delay > CNT_MAX) ? CNT_MAX : delay;
    end
    for (int i = 0; i < bp; i++) begin
      expect_eq("bp_rsp_valid", rspv(g), 1'b1);
      expect_eq("bp_rsp_cycles", rspc(g), exp_cyc);
      expect_eq("bp_other_quiet", {rspv(1 - g), rdy(0), rdy(1), ap_start}, 4'b0000);
      step();
    end
    set_rsp_ready(g, 1'b1);
    #1;
    expect_eq("rsp_valid", rspv(g), 1'b1);
    expect_eq("rsp_other", rspv(1 - g), 1'b0);
    expect_eq("rsp_cycles", rspc(g), exp_cyc);
    expect_eq("ctrl_hold", {ctrl_addr_offset, ctrl_constant}, {ea, ec});
    expect_eq("job_count_pre", job_count, exp_jobs);
    step();
    set_rsp_ready(g, 1'b0);
    exp_jobs    = exp_jobs + 1;
    last_served = g;
    expect_eq("idle_after_rsp", busy, 1'b0);
    expect_eq("rsp_dropped", {rspv(0), rspv(1)}, 2'b00);
    expect_eq("job_count", job_count, exp_jobs);
  endtask

  initial begin
    bus.s0_cmd_valid = 1'b0; bus.s1_cmd_valid = 1'b0;
    bus.s0_rsp_ready = 1'b0; bus.s1_rsp_ready = 1'b0;
    bus.s0_cmd_addr = '0; bus.s0_cmd_size = '0; bus.s0_cmd_constant = '0;
    bus.s1_cmd_addr = '0; bus.s1_cmd_size = '0; bus.s1_cmd_constant = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;

    // Contention from reset, first job doubles as the single-job case.
    post(0, 64'h1000, 32'd4096, 32'd5);
    post(1, 64'h2000, 32'd64, 32'd7);
    step();
    step();
    expect_eq("rst_cmd_ready", {rdy(0), rdy(1)}, 2'b00);
    expect_eq("rst_busy", busy, 1'b0);
    expect_eq("rst_ap_start", ap_start, 1'b0);
    expect_eq("rst_job_count", job_count, 32'd0);
    expect_eq("rst_ctrl", {ctrl_addr_offset, ctrl_xfer_size_in_bytes, ctrl_constant}, '0);
    expect_eq("rst_rsp_valid", {rspv(0), rspv(1)}, 2'b00);
    aresetn = 1'b1;
    run_job(100, 0, 1'b0);
    post(0, 64'h3000, 32'd128, 32'd9);
    run_job(7, 0, 1'b0);
    run_job(3, 1, 1'b0);

    // Zero size, back-pressure with a stalled second requester, spurious done, saturation.
    post(1, 64'h44, 32'd0, 32'd3);
    run_job(1, 0, 1'b0);
    post(0, 64'h5000, 32'd16, 32'd1);
    post(1, 64'h6000, 32'd32, 32'd2);
    run_job(4, 20, 1'b0);
    run_job(1, 0, 1'b0);
    post(0, 64'h7000, 32'd8, 32'd4);
    run_job(6, 2, 1'b1);
    post(1, 64'h8000, 32'd8, 32'd4);
    run_job(300, 0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && ($urandom_range(0, 1) == 1)) begin
          post(n, {$urandom(), $urandom()},
               ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(), $urandom());
        end
      end
      if (!pend[0] && !pend[1]) post($urandom_range(0, 1), {$urandom(), $urandom()}, $urandom(), $urandom());
      run_job($urandom_range(1, 12), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end

    // Abandon a job in WAIT via reset, then show recovery.
    set_valid(0, 1'b0); set_valid(1, 1'b0);
    pend[0] = 1'b0; pend[1] = 1'b0;
    post(0, 64'h9000, 32'd16, 32'd6);
    #1;
    step();
    set_valid(0, 1'b0);
    pend[0] = 1'b0;
    expect_eq("wr_start", ap_start, 1'b1);
    step();
    step();
    aresetn = 1'b0;
    step();
    expect_eq("wr_busy", busy, 1'b0);
    expect_eq("wr_job_count", job_count, 32'd0);
    expect_eq("wr_ctrl", {ctrl_addr_offset, ctrl_xfer_size_in_bytes, ctrl_constant}, '0);
    aresetn = 1'b1;
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_eq("wr_no_rsp", {rspv(0), rspv(1), ap_start, busy}, 4'b0000);
      step();
    end
    exp_jobs = 0;
    last_served = 1;
    post(1, 64'hA000, 32'd24, 32'd8);
    run_job(5, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axonerve_kvs_rtl_example_job_arbiter.md
AXONERVE_KVS_RTL_EXAMPLE_JOB_ARBITER -- requirements
Module: axonerve_kvs_rtl_example_job_arbiter

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 64, width of job address offset.
REQ-002 SHALL have parameter C_XFER_SIZE_WIDTH, default 32, width of job byte count.
REQ-003 SHALL have parameter C_ADDER_BIT_WIDTH, default 32, width of job adder constant.
REQ-004 SHALL have parameter C_CYCLE_CNT_WIDTH, default 32, width of per-job cycle count.
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 Port aclk, input, 1, the single clock; all logic on its rising edge.
REQ-007 Port aresetn, input, 1, synchronous active-low reset.
REQ-008 Ports sN_cmd_valid / sN_cmd_ready, N=0,1, input / output, 1 each, command handshake for requester N.
REQ-009 Ports sN_cmd_addr / sN_cmd_size / sN_cmd_constant, input, C_M_AXI_ADDR_WIDTH / C_XFER_SIZE_WIDTH / C_ADDER_BIT_WIDTH, job fields of requester N.
REQ-010 Ports sN_rsp_valid / sN_rsp_ready, output / input, 1 each, completion handshake for requester N.
REQ-011 Port sN_rsp_cycles, output, C_CYCLE_CNT_WIDTH, job duration in aclk cycles.
REQ-012 Ports ap_start (output, 1) and ap_done (input, 1), start pulse and done pulse of the shared vadd datapath.
REQ-013 Ports ctrl_addr_offset / ctrl_xfer_size_in_bytes / ctrl_constant, output, same widths as REQ-009, registered job fields to the datapath.
REQ-014 Ports busy (output, 1, state not IDLE) and job_count (output, 32, completed jobs).

Function
REQ-015 SHALL implement states IDLE, START, WAIT, RESP.
REQ-016 IDLE: sN_cmd_ready = 1 only for grant_next, combinational; all other cmd_ready 0; in other states all cmd_ready 0.
REQ-017 grant_next: the sole valid requester; if both valid, the requester not equal to last_grant (round-robin).
REQ-018 On accept (valid & ready) in IDLE: latch grant and the three fields into ctrl_* registers; go START, or RESP with rsp_cycles = 0 if size == 0 (no ap_start issued).
REQ-019 START: ap_start = 1 for exactly this one cycle; clear cycle counter to 0; go WAIT.
REQ-020 WAIT: counter increments by 1 per cycle, saturating at all-ones; on ap_done = 1 go RESP; rsp_cycles = D - S (S = ap_start cycle, D = ap_done cycle), saturated.
REQ-021 ap_done outside WAIT SHALL be ignored, including ap_done in the START cycle.
REQ-022 ctrl_* SHALL hold stable from the accept edge until the next accept.
REQ-023 RESP: s<grant>_rsp_valid = 1 with rsp_cycles stable until rsp_ready; other rsp_valid 0.
REQ-024 On rsp handshake: last_grant <= grant, job_count += 1 (wraps 2^32-1 -> 0), go IDLE; new command acceptable the next cycle.
REQ-025 Latency: accept at cycle T -> ap_start at T+1; ap_done at D -> rsp_valid at D+1.
REQ-026 Only one job in flight; second requester stalls on cmd_ready = 0 without loss.

Reset
REQ-027 While aresetn = 0 at a clock edge: state IDLE, last_grant = 1, job_count = 0, counter = 0, ctrl_* = 0, ap_start = 0, all rsp_valid = 0.
REQ-028 During reset, cmd_ready SHALL be 0.
REQ-029 Reset mid-job SHALL abandon the job: no response, no re-issue of ap_start.

Verification
REQ-030 Single job: s0 addr=0x1000, size=4096, const=5 -> ctrl_* match, ap_start 1 cycle at T+1; ap_done 100 cycles later -> s0_rsp_valid, rsp_cycles=100, job_count=1.
REQ-031 Contention: both valid from reset -> s0 served first, then s1, then s0 again; each gets exactly one ap_start.
REQ-032 Zero size: s1 size=0 -> no ap_start, s1_rsp_valid at T+1 with rsp_cycles=0.
REQ-033 Back-pressure: hold s0_rsp_ready=0 for 20 cycles -> rsp_valid/rsp_cycles stable, s1 cmd_ready 0, no ap_start.
REQ-034 Spurious done: ap_done in IDLE and in START -> ignored, state unchanged, WAIT still entered.
REQ-035 Reset in WAIT, then ap_done -> no rsp_valid, busy=0, job_count=0, ctrl_*=0.
